// File: rtl/diff_pkg.sv
// diff_pkg: shared types and helpers for the sequential difference locator.
//   state_e            : scan FSM states (IDLE, SCAN, DONE)
//   DIFF_CHUNK_DEFAULT : default number of bits examined per scan cycle
//   clog2_min1()       : ceil(log2(n)), never less than 1, for sizing ports
package diff_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DIFF_CHUNK_DEFAULT = 8;

    // Width helper; returns at least 1 so degenerate sizes still give a
    // legal vector width.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/diff_chunk_prio.sv
// diff_chunk_prio: combinational lowest-set-bit finder for one chunk.
//   slice_i  : CHUNK-bit slice of the XOR word
//   any_o    : slice is nonzero
//   idx_o    : position of the lowest set bit (0 when none)
//   onehot_o : single-bit mask of that position (0 when none)
//   cnt_o    : population count of the slice (only with DIFF_COUNT_EN)
module diff_chunk_prio
    import diff_pkg::*;
#(
    parameter int CHUNK = DIFF_CHUNK_DEFAULT,
    localparam int LW   = clog2_min1(CHUNK),
    localparam int CW   = clog2_min1(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] slice_i,
    output logic             any_o,
    output logic [LW-1:0]    idx_o,
`ifdef DIFF_COUNT_EN
    output logic [CW-1:0]    cnt_o,
`endif
    output logic [CHUNK-1:0] onehot_o
);

    always_comb begin
        any_o    = |slice_i;
        // Two's-complement trick isolates the lowest set bit.
        onehot_o = slice_i & (~slice_i + CHUNK'(1));
        idx_o    = '0;
        // Walk downward so the lowest set bit is the last one written.
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (slice_i[i]) idx_o = LW'(i);
        end
    end

`ifdef DIFF_COUNT_EN
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < CHUNK; i++) begin
            cnt_o = cnt_o + CW'(slice_i[i]);
        end
    end
`endif

endmodule

// File: rtl/diff_locator_seq.sv
// diff_locator_seq: multi-cycle locator of the lowest bit where a and b differ.
// Scans a^b from LSB upward, CHUNK bits per clock, valid/ready on both sides.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : operand handshake (accepted only in IDLE)
//   a, b                 : operands, sampled on the accepting edge
//   out_valid/out_ready  : result handshake (result held in DONE)
//   diff_found           : at least one bit differs
//   diff_onehot/diff_idx : lowest differing bit as mask / binary index
//   diff_cnt             : total differing bits (only with DIFF_COUNT_EN)
// Optional macro DIFF_COUNT_EN: full scan of every chunk with popcount
// accumulation; first-difference fields latch on the first nonzero chunk.
module diff_locator_seq
    import diff_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CHUNK  = DIFF_CHUNK_DEFAULT,
    localparam int IDXW  = clog2_min1(WIDTH),
    localparam int CNTW  = clog2_min1(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             diff_found,
    output logic [WIDTH-1:0] diff_onehot,
`ifdef DIFF_COUNT_EN
    output logic [CNTW-1:0]  diff_cnt,
`endif
    output logic [IDXW-1:0]  diff_idx
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = clog2_min1(NCHUNK);
    localparam int LW     = clog2_min1(CHUNK);
    localparam int CW     = clog2_min1(CHUNK + 1);

    if (WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("diff_locator_seq: WIDTH must be >= CHUNK and a multiple of CHUNK");
    end

    state_e            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [WIDTH-1:0]  x_q, x_d;
    logic              found_q, found_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  onehot_q, onehot_d;

    logic [CHUNK-1:0]  slice;
    logic              c_any;
    logic [LW-1:0]     c_idx;
    logic [CHUNK-1:0]  c_onehot;
    logic              last_chunk;
    logic              accept;

    assign slice      = CHUNK'(x_q >> (int'(k_q) * CHUNK));
    assign last_chunk = (k_q == KW'(NCHUNK - 1));
    assign accept     = (state_q == IDLE) && in_valid;

`ifdef DIFF_COUNT_EN
    logic [CW-1:0]     c_cnt;
    logic [CNTW-1:0]   cnt_q, cnt_d;
`endif

    diff_chunk_prio #(.CHUNK(CHUNK)) u_prio (
        .slice_i  (slice),
        .any_o    (c_any),
        .idx_o    (c_idx),
`ifdef DIFF_COUNT_EN
        .cnt_o    (c_cnt),
`endif
        .onehot_o (c_onehot)
    );

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = SCAN;
`ifdef DIFF_COUNT_EN
            SCAN: if (last_chunk) state_d = DONE;
`else
            SCAN: if (c_any || last_chunk) state_d = DONE;
`endif
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Datapath next state
    always_comb begin
        k_d      = k_q;
        x_d      = x_q;
        found_d  = found_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
`ifdef DIFF_COUNT_EN
        cnt_d    = cnt_q;
`endif
        if (accept) begin
            x_d      = a ^ b;
            k_d      = '0;
            found_d  = 1'b0;
            idx_d    = '0;
            onehot_d = '0;
`ifdef DIFF_COUNT_EN
            cnt_d    = '0;
`endif
        end else if (state_q == SCAN) begin
            if (!last_chunk) k_d = k_q + KW'(1);
`ifdef DIFF_COUNT_EN
            cnt_d = cnt_q + CNTW'(c_cnt);
            // Only the first nonzero chunk sets the position fields.
            if (c_any && !found_q) begin
`else
            if (c_any) begin
`endif
                found_d  = 1'b1;
                idx_d    = IDXW'(int'(k_q) * CHUNK) + IDXW'(c_idx);
                onehot_d = WIDTH'(c_onehot) << (int'(k_q) * CHUNK);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q      <= '0;
            x_q      <= '0;
            found_q  <= 1'b0;
            idx_q    <= '0;
            onehot_q <= '0;
`ifdef DIFF_COUNT_EN
            cnt_q    <= '0;
`endif
        end else begin
            k_q      <= k_d;
            x_q      <= x_d;
            found_q  <= found_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
`ifdef DIFF_COUNT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign diff_found  = found_q;
    assign diff_idx    = idx_q;
    assign diff_onehot = onehot_q;
`ifdef DIFF_COUNT_EN
    assign diff_cnt    = cnt_q;
`endif

endmodule

// File: tb/tb_diff_locator_seq.sv
// tb_diff_locator_seq: table-driven check of diff_locator_seq (WIDTH=32,
// CHUNK=8) plus hand-written stall and reset sequences.
module tb_diff_locator_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic        diff_found;
    logic [31:0] diff_onehot;
    logic [4:0]  diff_idx;
`ifdef DIFF_COUNT_EN
    logic [5:0]  diff_cnt;
    localparam bit CNT_MODE = 1'b1;
`else
    localparam bit CNT_MODE = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    diff_locator_seq #(.WIDTH(32), .CHUNK(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .diff_found  (diff_found),
        .diff_onehot (diff_onehot),
`ifdef DIFF_COUNT_EN
        .diff_cnt    (diff_cnt),
`endif
        .diff_idx    (diff_idx)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        found;
        int          idx;
        logic [31:0] onehot;
        int          lat;   // early-exit latency
        int          cnt;   // popcount of a^b
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " out_valid"},   32'(out_valid),   32'd0);
        check({tag, " in_ready"},    32'(in_ready),    32'd1);
        check({tag, " diff_found"},  32'(diff_found),  32'd0);
        check({tag, " diff_idx"},    32'(diff_idx),    32'd0);
        check({tag, " diff_onehot"}, diff_onehot,      32'd0);
`ifdef DIFF_COUNT_EN
        check({tag, " diff_cnt"},    32'(diff_cnt),    32'd0);
`endif
    endtask

    // Wait (bounded) for out_valid, sampling 1 time unit after each edge.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Present operands in IDLE, return cycles from accept to out_valid.
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, output int lat);
        @(negedge clk);
        a = av; b = bv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        wait_result(lat);
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " out_valid after pop"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready after pop"},  32'(in_ready),  32'd1);
    endtask

    initial begin
        int lat;
        int exp_lat;

        vecs[0] = '{32'h000000F0, 32'h00000000, 1'b1,  4, 32'h00000010, 1, 4};
        vecs[1] = '{32'h80000000, 32'h00000000, 1'b1, 31, 32'h80000000, 4, 1};
        vecs[2] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b0,  0, 32'h00000000, 4, 0};
        vecs[3] = '{32'h00010000, 32'h00000000, 1'b1, 16, 32'h00010000, 3, 1};
        vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFF7F, 1'b1,  7, 32'h00000080, 1, 1};
        vecs[5] = '{32'h00000300, 32'h00000100, 1'b1,  9, 32'h00000200, 2, 1};
        vecs[6] = '{32'h12345678, 32'h12F45678, 1'b1, 22, 32'h00400000, 3, 2};
        vecs[7] = '{32'hFFFF0001, 32'h00000000, 1'b1,  0, 32'h00000001, 1, 17};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        #1;
        check_zero_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, lat);
            exp_lat = CNT_MODE ? 4 : vecs[i].lat;
            check($sformatf("v%0d latency", i),  32'(lat),         32'(exp_lat));
            check($sformatf("v%0d in_ready", i), 32'(in_ready),    32'd0);
            check($sformatf("v%0d found", i),    32'(diff_found),  32'(vecs[i].found));
            check($sformatf("v%0d idx", i),      32'(diff_idx),    32'(vecs[i].idx));
            check($sformatf("v%0d onehot", i),   diff_onehot,      vecs[i].onehot);
`ifdef DIFF_COUNT_EN
            check($sformatf("v%0d cnt", i),      32'(diff_cnt),    32'(vecs[i].cnt));
`endif
            release_result($sformatf("v%0d", i));
        end

        // Stall in DONE with in_valid held high and new operands waiting
        do_op(32'h000000F0, 32'h0, lat);
        @(negedge clk);
        a = 32'h00000100; b = 32'h0; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("stall%0d out_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("stall%0d in_ready", c),  32'(in_ready),  32'd0);
            check($sformatf("stall%0d idx", c),       32'(diff_idx),  32'd4);
            check($sformatf("stall%0d onehot", c),    diff_onehot,    32'h10);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("stall pop out_valid", 32'(out_valid), 32'd0);
        check("stall pop in_ready",  32'(in_ready),  32'd1);
        check("stall pop held idx",  32'(diff_idx),  32'd4);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("stall accept in_ready", 32'(in_ready), 32'd0);
        wait_result(lat);
        check("stall next latency", 32'(lat),      CNT_MODE ? 32'd4 : 32'd2);
        check("stall next idx",     32'(diff_idx), 32'd8);
        release_result("stall next");

        // Reset during the second scan cycle
        @(negedge clk);
        a = 32'h80000000; b = 32'h0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("midscan still scanning", 32'(out_valid), 32'd0);
        rst = 1'b1;
        #1;
        check_zero_outputs("midscan rst");
        @(negedge clk);
        rst = 1'b0;
        do_op(32'h00000100, 32'h0, lat);
        check("post-rst idx",     32'(diff_idx),   32'd8);
        check("post-rst onehot",  diff_onehot,     32'h100);
        check("post-rst found",   32'(diff_found), 32'd1);

        // Reset while a result is waiting in DONE
        #1;
        rst = 1'b1;
        #1;
        check_zero_outputs("done rst");
        @(negedge clk);
        rst = 1'b0;
        do_op(32'h00000000, 32'h00000400, lat);
        check("post-done-rst idx", 32'(diff_idx), 32'd10);
        release_result("post-done-rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
